issue_scoreboard: RTL and testbench

- Sits between the instruction decoder and the execute stage. Holds one decoded instruction in a single-entry issue buffer.
- Tracks pending writes to the integer and FP register files in per-register busy bits.
- Issues an instruction only when it has no RAW or WAW hazard and execute is ready.
- Serialises control flow: after a branch or jump issues, no further issue until execute reports resolution.

---
 rtl/issue_scoreboard_pkg.sv | 28 ++
 rtl/issue_scoreboard_busy_table.sv | 60 ++++++
 rtl/issue_scoreboard.sv | 140 ++++++++++++++
 tb/tb_issue_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard.
//   NREG / REG_W : architectural registers per file and their index width
//   issue_state_e: issue gating state (RUN, WAIT_CTRL)
//   issue_entry_t: decoded fields held in the single-entry issue buffer
package issue_scoreboard_pkg;

    localparam int NREG  = 32;
    localparam int REG_W = 5;

    typedef enum logic {
        RUN       = 1'b0,
        WAIT_CTRL = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             use_rs1;
        logic             use_rs2;
        logic             rs1_f;
        logic             rs2_f;
        logic             rd_f;
        logic             writes_rd;
        logic             is_ctrl;
    } issue_entry_t;

endpackage

// File: rtl/issue_scoreboard_busy_table.sv
// Busy-bit table for the integer and FP register files.
//   set_*   : mark a register busy (wins over a same-cycle clear)
//   clr_*   : writeback completed, clear the register's busy bit
//   a_*/b_* : source read ports, d_* : destination read port
// Integer x0 is held at zero so it never reads busy; FP f0 is ordinary.
module busy_table
    import issue_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             set_f,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic             clr_f,
    input  logic [REG_W-1:0] a_idx,
    input  logic             a_f,
    output logic             a_busy,
    input  logic [REG_W-1:0] b_idx,
    input  logic             b_f,
    output logic             b_busy,
    input  logic [REG_W-1:0] d_idx,
    input  logic             d_f,
    output logic             d_busy
);

    logic [NREG-1:0] busy_int_q, busy_int_d;
    logic [NREG-1:0] busy_fp_q,  busy_fp_d;

    always_comb begin
        busy_int_d = busy_int_q;
        busy_fp_d  = busy_fp_q;
        // Clear first so a set to the same register in this cycle wins.
        if (clr_en) begin
            if (clr_f) busy_fp_d[clr_idx]  = 1'b0;
            else       busy_int_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            if (set_f) busy_fp_d[set_idx]  = 1'b1;
            else       busy_int_d[set_idx] = 1'b1;
        end
        busy_int_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_int_q <= '0;
            busy_fp_q  <= '0;
        end else begin
            busy_int_q <= busy_int_d;
            busy_fp_q  <= busy_fp_d;
        end
    end

    assign a_busy = a_f ? busy_fp_q[a_idx] : busy_int_q[a_idx];
    assign b_busy = b_f ? busy_fp_q[b_idx] : busy_int_q[b_idx];
    assign d_busy = d_f ? busy_fp_q[d_idx] : busy_int_q[d_idx];

endmodule

// File: rtl/issue_scoreboard.sv
// Single-entry issue buffer with RAW/WAW scoreboarding and control-flow
// serialisation, between the decoder and the execute stage.
//   dec_*         : decoded instruction in, dec_valid/dec_ready handshake
//   issue_*       : buffered instruction out, issue_valid/issue_ready handshake
//   wb_*          : writeback completions that release busy registers
//   ctrl_resolved : execute resolved the outstanding branch/jump
//   flush         : squash the buffered instruction
//   stall_cycles  : count of cycles the buffer held an instruction that did not issue
// Register-file geometry (NREG, REG_W) comes from issue_scoreboard_pkg.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RUN       | normal issue, gated only by hazards and buffer occupancy
// WAIT_CTRL | a control instruction issued; hold issue until resolved
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic             dec_rs1_f,
    input  logic             dec_rs2_f,
    input  logic             dec_rd_f,
    input  logic             dec_writes_rd,
    input  logic             dec_is_ctrl,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [REG_W-1:0] issue_rd,
    output logic             issue_rd_f,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_f,
    input  logic             ctrl_resolved,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cycles
);

    issue_entry_t buf_q, buf_d;
    logic         buf_valid_q, buf_valid_d;
    issue_state_e state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic rs1_busy, rs2_busy, rd_busy;
    logic hazard, issue_fire, accept;
    issue_entry_t dec_entry;

    assign dec_entry = '{
        rs1:       dec_rs1,
        rs2:       dec_rs2,
        rd:        dec_rd,
        use_rs1:   dec_use_rs1,
        use_rs2:   dec_use_rs2,
        rs1_f:     dec_rs1_f,
        rs2_f:     dec_rs2_f,
        rd_f:      dec_rd_f,
        writes_rd: dec_writes_rd,
        is_ctrl:   dec_is_ctrl
    };

    busy_table u_busy (
        .clk     (clk),
        .rstn    (rstn),
        .set_en  (issue_fire && buf_q.writes_rd),
        .set_idx (buf_q.rd),
        .set_f   (buf_q.rd_f),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .clr_f   (wb_f),
        .a_idx   (buf_q.rs1),
        .a_f     (buf_q.rs1_f),
        .a_busy  (rs1_busy),
        .b_idx   (buf_q.rs2),
        .b_f     (buf_q.rs2_f),
        .b_busy  (rs2_busy),
        .d_idx   (buf_q.rd),
        .d_f     (buf_q.rd_f),
        .d_busy  (rd_busy)
    );

    // Hazards look only at registered busy bits: a writeback this cycle
    // releases the stalled instruction on the next cycle, not this one.
    assign hazard = (buf_q.use_rs1   && rs1_busy) ||
                    (buf_q.use_rs2   && rs2_busy) ||
                    (buf_q.writes_rd && rd_busy);

    assign issue_valid = buf_valid_q && !hazard && (state_q == RUN);
    assign issue_fire  = issue_valid && issue_ready;
    // Refill in the issuing cycle keeps one-per-cycle throughput.
    assign dec_ready   = !flush && (!buf_valid_q || issue_fire);
    assign accept      = dec_valid && dec_ready;

    assign issue_rd     = buf_q.rd;
    assign issue_rd_f   = buf_q.rd_f;
    assign stall_cycles = stall_q;

    always_comb begin
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        state_d     = state_q;
        stall_d     = stall_q;

        if (accept) buf_d = dec_entry;

        if (flush)           buf_valid_d = 1'b0;
        else if (accept)     buf_valid_d = 1'b1;
        else if (issue_fire) buf_valid_d = 1'b0;

        case (state_q)
            RUN:       if (issue_fire && buf_q.is_ctrl) state_d = WAIT_CTRL;
            WAIT_CTRL: if (ctrl_resolved)               state_d = RUN;
            default:                                    state_d = RUN;
        endcase
        if (flush) state_d = RUN;

        if (buf_valid_q && !issue_fire && !flush) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            state_q     <= RUN;
            stall_q     <= '0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            state_q     <= state_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dec_valid, dec_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_rs1, dec_use_rs2, dec_rs1_f, dec_rs2_f, dec_rd_f;
    logic        dec_writes_rd, dec_is_ctrl;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd;
    logic        issue_rd_f;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_f;
    logic        ctrl_resolved, flush;
    logic [31:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rs1_f(dec_rs1_f), .dec_rs2_f(dec_rs2_f), .dec_rd_f(dec_rd_f),
        .dec_writes_rd(dec_writes_rd), .dec_is_ctrl(dec_is_ctrl),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rd(issue_rd), .issue_rd_f(issue_rd_f),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_f(wb_f),
        .ctrl_resolved(ctrl_resolved), .flush(flush),
        .stall_cycles(stall_cycles)
    );

    // flag order: {use_rs1, use_rs2, rs1_f, rs2_f, rd_f, writes_rd, is_ctrl}
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_ADD  = 7'b1100010;
    localparam logic [6:0] F_ADDI = 7'b1000010;
    localparam logic [6:0] F_FDST = 7'b0000110;
    localparam logic [6:0] F_BEQ  = 7'b1100001;
    localparam logic [6:0] F_FRD1 = 7'b1010010;

    typedef struct {
        logic       dv;
        logic [4:0] rs1, rs2, rd;
        logic [6:0] fl;
        logic       ir, wbv;
        logic [4:0] wbrd;
        logic       wbf, cres;
        logic       eiv, edr;
        int         est;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic dv, input int rs1, input int rs2, input int rd,
                               input logic [6:0] fl, input logic ir, input logic wbv,
                               input int wbrd, input logic wbf, input logic cres,
                               input logic eiv, input logic edr, input int est);
        vec_t r;
        r.dv = dv; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd); r.fl = fl;
        r.ir = ir; r.wbv = wbv; r.wbrd = 5'(wbrd); r.wbf = wbf; r.cres = cres;
        r.eiv = eiv; r.edr = edr; r.est = est;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ins(input logic dv, input int rs1, input int rs2, input int rd,
                           input logic [6:0] fl);
        dec_valid = dv;
        dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rd = 5'(rd);
        {dec_use_rs1, dec_use_rs2, dec_rs1_f, dec_rs2_f, dec_rd_f, dec_writes_rd, dec_is_ctrl} = fl;
    endtask

    task automatic clear_inputs();
        set_ins(1'b0, 0, 0, 0, F_NONE);
        issue_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_f = 1'b0;
        ctrl_resolved = 1'b0; flush = 1'b0;
    endtask

    // Inputs are driven at posedge+1; outputs are sampled at posedge+3.
    task automatic step_chk(input string tag, input logic eiv, input logic edr, input int est);
        #2;
        chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(eiv));
        chk({tag, ".dec_ready"},   32'(dec_ready),   32'(edr));
        chk({tag, ".stall"},       stall_cycles,     32'(est));
        @(posedge clk); #1;
    endtask

    // Reference model for the random phase
    bit           m_busy [2][32];
    bit           m_bv, m_wait;
    issue_entry_t m_buf;
    logic [31:0]  m_stall;
    bit           m_iv, m_fire, m_dr;

    task automatic model_reset();
        foreach (m_busy[f, r]) m_busy[f][r] = 1'b0;
        m_bv = 0; m_wait = 0; m_buf = '0; m_stall = '0;
    endtask

    function automatic bit m_isbusy(input logic f, input logic [4:0] r);
        if (!f && r == 0) return 1'b0;
        return m_busy[f][r];
    endfunction

    task automatic model_comb();
        bit haz;
        haz = (m_buf.use_rs1 && m_isbusy(m_buf.rs1_f, m_buf.rs1)) ||
              (m_buf.use_rs2 && m_isbusy(m_buf.rs2_f, m_buf.rs2)) ||
              (m_buf.writes_rd && m_isbusy(m_buf.rd_f, m_buf.rd));
        m_iv   = m_bv && !haz && !m_wait;
        m_fire = m_iv && issue_ready;
        m_dr   = !flush && (!m_bv || m_fire);
    endtask

    task automatic model_update();
        bit acc;
        acc = dec_valid && m_dr;
        if (wb_valid) m_busy[wb_f][wb_rd] = 1'b0;
        if (m_fire && m_buf.writes_rd && !(!m_buf.rd_f && m_buf.rd == 0))
            m_busy[m_buf.rd_f][m_buf.rd] = 1'b1;
        if (m_bv && !m_fire && !flush) m_stall = m_stall + 1;
        if (flush)                     m_wait = 0;
        else if (m_fire && m_buf.is_ctrl) m_wait = 1;
        else if (m_wait && ctrl_resolved) m_wait = 0;
        if (acc) begin
            m_buf.rs1 = dec_rs1; m_buf.rs2 = dec_rs2; m_buf.rd = dec_rd;
            m_buf.use_rs1 = dec_use_rs1; m_buf.use_rs2 = dec_use_rs2;
            m_buf.rs1_f = dec_rs1_f; m_buf.rs2_f = dec_rs2_f; m_buf.rd_f = dec_rd_f;
            m_buf.writes_rd = dec_writes_rd; m_buf.is_ctrl = dec_is_ctrl;
        end
        if (flush)       m_bv = 0;
        else if (acc)    m_bv = 1;
        else if (m_fire) m_bv = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        #12;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        #12;
        rstn = 1'b1;
        @(posedge clk); #1;

        #2;
        chk("rst.issue_valid", 32'(issue_valid), 32'd0);
        chk("rst.dec_ready",   32'(dec_ready),   32'd1);
        chk("rst.stall",       stall_cycles,     32'd0);
        chk("rst.issue_rd",    32'(issue_rd),    32'd0);
        @(posedge clk); #1;

        // RAW stall and release
        vecs.push_back(v(1, 1, 2, 5,  F_ADD,  1, 0, 0,  0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 1, 1, 0));
        vecs.push_back(v(1, 5, 6, 8,  F_ADD,  1, 0, 0,  0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 1, 5,  0, 0, 0, 0, 2));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 1, 1, 3));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 1, 8,  0, 0, 0, 1, 3));
        // FP/int separation: f3 busy does not block a reader of x3
        vecs.push_back(v(1, 0, 0, 3,  F_FDST, 1, 0, 0,  0, 0, 0, 1, 3));
        vecs.push_back(v(1, 3, 0, 9,  F_ADDI, 1, 0, 0,  0, 0, 1, 1, 3));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 1, 1, 3));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 1, 9,  0, 0, 0, 1, 3));
        // set wins over same-cycle writeback of x7
        vecs.push_back(v(1, 1, 0, 7,  F_ADDI, 1, 0, 0,  0, 0, 0, 1, 3));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 1, 7,  0, 0, 1, 1, 3));
        vecs.push_back(v(1, 7, 0, 10, F_ADDI, 1, 0, 0,  0, 0, 0, 1, 3));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 0, 0, 3));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 1, 7,  0, 0, 0, 0, 4));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 1, 1, 5));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 1, 10, 0, 0, 0, 1, 5));
        // x0 never busy
        vecs.push_back(v(1, 0, 0, 0,  F_ADDI, 1, 0, 0,  0, 0, 0, 1, 5));
        vecs.push_back(v(1, 0, 0, 11, F_ADD,  1, 0, 0,  0, 0, 1, 1, 5));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 1, 1, 5));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 1, 11, 0, 0, 0, 1, 5));
        // control serialisation
        vecs.push_back(v(1, 1, 2, 0,  F_BEQ,  1, 0, 0,  0, 0, 0, 1, 5));
        vecs.push_back(v(1, 1, 0, 12, F_ADDI, 1, 0, 0,  0, 0, 1, 1, 5));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 0, 0, 5));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 1, 0, 0, 6));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 1, 1, 7));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 1, 12, 0, 0, 0, 1, 7));
        // execute not ready
        vecs.push_back(v(1, 1, 0, 13, F_ADDI, 1, 0, 0,  0, 0, 0, 1, 7));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 0, 0, 0,  0, 0, 1, 0, 7));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 0, 0,  0, 0, 1, 1, 8));
        vecs.push_back(v(0, 0, 0, 0,  F_NONE, 1, 1, 13, 0, 0, 0, 1, 8));

        for (int i = 0; i < vecs.size(); i++) begin
            set_ins(vecs[i].dv, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].fl);
            issue_ready = vecs[i].ir; wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbrd;
            wb_f = vecs[i].wbf; ctrl_resolved = vecs[i].cres; flush = 1'b0;
            step_chk($sformatf("vec%0d", i), vecs[i].eiv, vecs[i].edr, vecs[i].est);
        end
        clear_inputs();

        // Flush of a hazarded instruction (f3 still busy from the table)
        set_ins(1, 3, 0, 14, F_FRD1);
        step_chk("fl_acc", 0, 1, 8);
        set_ins(0, 0, 0, 0, F_NONE);
        #2 chk("fl_issue_rd", 32'(issue_rd), 32'd14);
        #0 step_chk("fl_haz", 0, 0, 8);
        flush = 1'b1; set_ins(1, 1, 2, 20, F_ADD);
        step_chk("fl_on", 0, 0, 9);
        flush = 1'b0; set_ins(0, 0, 0, 0, F_NONE);
        step_chk("fl_after", 0, 1, 9);
        set_ins(1, 3, 0, 14, F_FRD1);
        step_chk("fl_reacc", 0, 1, 9);
        set_ins(0, 0, 0, 0, F_NONE);
        step_chk("fl_busy_kept", 0, 0, 9);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_f = 1'b1;
        step_chk("fl_wb", 0, 0, 10);
        wb_valid = 1'b0;
        step_chk("fl_wb_rel", 1, 1, 11);

        // Async reset in the middle of a stall (x14 now busy)
        set_ins(1, 14, 0, 15, F_ADDI);
        step_chk("ar_acc", 0, 1, 11);
        set_ins(0, 0, 0, 0, F_NONE);
        step_chk("ar_stall0", 0, 0, 11);
        step_chk("ar_stall1", 0, 0, 12);
        #2 rstn = 1'b0;
        #1;
        chk("ar.issue_valid", 32'(issue_valid), 32'd0);
        chk("ar.dec_ready",   32'(dec_ready),   32'd1);
        chk("ar.stall",       stall_cycles,     32'd0);
        chk("ar.issue_rd",    32'(issue_rd),    32'd0);
        chk("ar.issue_rd_f",  32'(issue_rd_f),  32'd0);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        set_ins(1, 14, 0, 15, F_ADDI);
        step_chk("ar_reacc", 0, 1, 0);
        set_ins(0, 0, 0, 0, F_NONE);
        step_chk("ar_busy_clr", 1, 1, 0);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            set_ins($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7),
                    {1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), $urandom_range(0, 9) == 0});
            issue_ready   = $urandom_range(0, 3) != 0;
            wb_valid      = $urandom_range(0, 1) == 0;
            wb_rd         = 5'($urandom_range(0, 7));
            wb_f          = 1'($urandom);
            ctrl_resolved = $urandom_range(0, 4) == 0;
            flush         = $urandom_range(0, 19) == 0;
            #2;
            model_comb();
            chk("rnd.issue_valid", 32'(issue_valid), 32'(m_iv));
            chk("rnd.dec_ready",   32'(dec_ready),   32'(m_dr));
            chk("rnd.issue_rd",    32'(issue_rd),    32'(m_buf.rd));
            chk("rnd.issue_rd_f",  32'(issue_rd_f),  32'(m_buf.rd_f));
            chk("rnd.stall",       stall_cycles,     m_stall);
            @(posedge clk);
            model_update();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
